// File: rtl/ball_collision_detect.sv
// Per-frame ball collision classifier for a two-paddle game: samples positions on
// frame_tick, resolves one prioritised collision code and strobes calc_start.
module ball_collision_detect #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int BALL_SIZE      = 8,
    parameter int PADDLE_W       = 8,
    parameter int PADDLE_H       = 64,
    parameter int PADDLE_L_X     = 16,
    parameter int PADDLE_R_X     = 616,
    parameter int LOCKOUT_FRAMES = 4
) (
    input  logic       clk_100MHz,
    input  logic       Reset,
    input  logic       game_start,
    input  logic       frame_tick,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [2:0] collision,
    output logic       calc_start
);

    localparam int LW = (LOCKOUT_FRAMES < 1) ? 1 : $clog2(LOCKOUT_FRAMES + 1);

    localparam logic [10:0] BS  = 11'(BALL_SIZE);
    localparam logic [10:0] SW  = 11'(SCREEN_W);
    localparam logic [10:0] SH  = 11'(SCREEN_H);
    localparam logic [10:0] PW  = 11'(PADDLE_W);
    localparam logic [10:0] PH  = 11'(PADDLE_H);
    localparam logic [10:0] PLX = 11'(PADDLE_L_X);
    localparam logic [10:0] PRX = 11'(PADDLE_R_X);

    localparam logic [2:0] C_NONE   = 3'b000;
    localparam logic [2:0] C_PADDLE = 3'b001;
    localparam logic [2:0] C_TOP    = 3'b010;
    localparam logic [2:0] C_BOTTOM = 3'b011;
    localparam logic [2:0] C_GOAL_L = 3'b100;
    localparam logic [2:0] C_GOAL_R = 3'b101;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        SAMPLE     = 3'd2,
        EVAL       = 3'd3,
        REPORT     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    bx_q, bx_d, by_q, by_d, pl_q, pl_d, pr_q, pr_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [2:0]    coll_q, coll_d;
    logic          cs_q, cs_d;

    logic [10:0]   bx_s, by_s, pl_s, pr_s;
    logic [2:0]    code_s;

    // Axis-aligned overlap of the ball square with one paddle rectangle, 11-bit sums.
    function automatic logic paddle_hit(input logic [10:0] bx, input logic [10:0] by,
                                        input logic [10:0] px, input logic [10:0] py);
        return (bx < px + PW) && (bx + BS > px) && (by + BS > py) && (by < py + PH);
    endfunction

    // Resolve the sampled frame into a single code; paddle hits are masked during lockout.
    always_comb begin
        bx_s = {1'b0, bx_q};
        by_s = {1'b0, by_q};
        pl_s = {1'b0, pl_q};
        pr_s = {1'b0, pr_q};
        if (bx_s == 11'd0) begin
            code_s = C_GOAL_L;
        end else if (bx_s + BS >= SW) begin
            code_s = C_GOAL_R;
        end else if ((lock_q == '0) &&
                     (paddle_hit(bx_s, by_s, PLX, pl_s) || paddle_hit(bx_s, by_s, PRX, pr_s))) begin
            code_s = C_PADDLE;
        end else if (by_s == 11'd0) begin
            code_s = C_TOP;
        end else if (by_s + BS >= SH) begin
            code_s = C_BOTTOM;
        end else begin
            code_s = C_NONE;
        end
    end

    // Next-state, sample capture and report logic; dropping game_start overrides everything.
    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        pl_d    = pl_q;
        pr_d    = pr_q;
        lock_d  = lock_q;
        coll_d  = coll_q;
        cs_d    = 1'b0;
        if (!game_start) begin
            state_d = IDLE;
            coll_d  = C_NONE;
            lock_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (frame_tick) begin
                        state_d = SAMPLE;
                        bx_d    = ball_x;
                        by_d    = ball_y;
                        pl_d    = paddle_l_y;
                        pr_d    = paddle_r_y;
                    end else begin
                        state_d = WAIT_FRAME;
                    end
                end
                SAMPLE: begin
                    state_d = EVAL;
                end
                EVAL: begin
                    // Outputs and lockout are registered here so they are visible in REPORT.
                    state_d = REPORT;
                    if (code_s != C_NONE) begin
                        coll_d = code_s;
                        cs_d   = 1'b1;
                    end else begin
                        coll_d = coll_q;
                    end
                    if (code_s == C_PADDLE) begin
                        lock_d = LW'(LOCKOUT_FRAMES);
                    end else if (lock_q != '0) begin
                        lock_d = lock_q - LW'(1);
                    end else begin
                        lock_d = lock_q;
                    end
                end
                REPORT: begin
                    state_d = WAIT_FRAME;
                end
                default: begin
                    state_d = IDLE;
                    coll_d  = C_NONE;
                    lock_d  = '0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_100MHz) begin
        if (Reset) begin
            state_q <= IDLE;
            bx_q    <= 10'd0;
            by_q    <= 10'd0;
            pl_q    <= 10'd0;
            pr_q    <= 10'd0;
            lock_q  <= '0;
            coll_q  <= 3'b000;
            cs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            pl_q    <= pl_d;
            pr_q    <= pr_d;
            lock_q  <= lock_d;
            coll_q  <= coll_d;
            cs_q    <= cs_d;
        end
    end

    assign collision  = coll_q;
    assign calc_start = cs_q;

endmodule

// File: tb/tb_ball_collision_detect.sv
// Directed bench for ball_collision_detect: a frame-level transaction model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_ball_collision_detect;

    localparam int LOCK = 4;

    logic       clk_100MHz = 1'b0;
    logic       Reset      = 1'b1;
    logic       game_start = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] ball_x     = 10'd0;
    logic [9:0] ball_y     = 10'd0;
    logic [9:0] paddle_l_y = 10'd80;
    logic [9:0] paddle_r_y = 10'd200;
    logic [2:0] collision;
    logic       calc_start;

    int total = 0;
    int bad   = 0;

    ball_collision_detect dut (
        .clk_100MHz (clk_100MHz),
        .Reset      (Reset),
        .game_start (game_start),
        .frame_tick (frame_tick),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .collision  (collision),
        .calc_start (calc_start)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Collision rules written directly as integer geometry with fixed priority.
    function automatic int classify(input int bx, input int by, input int pl, input int pr,
                                    input int lock);
        bit hl, hr;
        hl = (bx < 16 + 8) && (bx + 8 > 16) && (by + 8 > pl) && (by < pl + 64);
        hr = (bx < 616 + 8) && (bx + 8 > 616) && (by + 8 > pr) && (by < pr + 64);
        if (bx == 0) return 4;
        if (bx + 8 >= 640) return 5;
        if (lock == 0 && (hl || hr)) return 1;
        if (by == 0) return 2;
        if (by + 8 >= 480) return 3;
        return 0;
    endfunction

    // Frame-transaction model: an accepted tick becomes one evaluation two edges later.
    int m_cyc = 0, m_accept = 0, m_eval = 0, m_lock = 0, m_coll = 0, m_cs = 0;
    bit m_idle = 1'b1, m_pend = 1'b0;
    int c_bx, c_by, c_pl, c_pr;

    always @(posedge clk_100MHz) begin
        int code;
        m_cs = 0;
        if (Reset || !game_start) begin
            m_idle = 1'b1; m_coll = 0; m_lock = 0; m_pend = 1'b0;
        end else if (m_idle) begin
            m_idle   = 1'b0;
            m_accept = m_cyc + 1;
        end else begin
            if (m_pend && m_cyc == m_eval) begin
                code = classify(c_bx, c_by, c_pl, c_pr, m_lock);
                if (code != 0) begin
                    m_coll = code;
                    m_cs   = 1;
                end
                if (code == 1) m_lock = LOCK;
                else if (m_lock > 0) m_lock = m_lock - 1;
                m_pend = 1'b0;
            end
            if (!m_pend && frame_tick && m_cyc >= m_accept) begin
                c_bx = int'(ball_x); c_by = int'(ball_y);
                c_pl = int'(paddle_l_y); c_pr = int'(paddle_r_y);
                m_pend   = 1'b1;
                m_eval   = m_cyc + 2;
                m_accept = m_cyc + 4;
            end
        end
        m_cyc++;
        #1;
        chk("model_calc_start", int'(calc_start), m_cs);
        chk("model_collision", int'(collision), m_coll);
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #2;
        end
    endtask

    task automatic set_ball(input int bx, input int by);
        ball_x = 10'(bx);
        ball_y = 10'(by);
    endtask

    // One full frame from WAIT_FRAME; literal checks at N+2, N+3, N+4.
    task automatic do_frame(input string nm, input int bx, input int by,
                            input int ecs, input int ecoll);
        set_ball(bx, by);
        frame_tick = 1'b1;
        wait_cyc(1);
        frame_tick = 1'b0;
        wait_cyc(1);
        chk({nm, "_early"}, int'(calc_start), 0);
        wait_cyc(1);
        chk({nm, "_cs"}, int'(calc_start), ecs);
        chk({nm, "_coll"}, int'(collision), ecoll);
        wait_cyc(1);
        chk({nm, "_cs_off"}, int'(calc_start), 0);
    endtask

    initial begin
        wait_cyc(3);
        chk("reset_cs", int'(calc_start), 0);
        chk("reset_coll", int'(collision), 0);
        Reset      = 1'b0;
        game_start = 1'b1;
        wait_cyc(2);

        do_frame("paddle_first", 20, 100, 1, 1);
        for (int i = 1; i <= 4; i++) do_frame("lockout", 20, 100, 0, 1);
        do_frame("lockout_end", 20, 100, 1, 1);
        do_frame("left_goal", 0, 0, 1, 4);
        do_frame("right_goal", 632, 472, 1, 5);
        do_frame("top_wall", 300, 0, 1, 2);
        do_frame("bottom_wall", 300, 472, 1, 3);
        do_frame("no_hit_hold", 300, 200, 0, 3);

        paddle_r_y = 10'd280;
        do_frame("right_paddle", 612, 300, 1, 1);
        do_frame("bottom_edge", 300, 471, 0, 1);
        do_frame("near_corner", 1, 1, 0, 1);
        do_frame("right_edge", 631, 5, 0, 1);
        do_frame("paddle_edge_miss", 24, 100, 0, 1);
        do_frame("paddle_edge_hit", 23, 100, 1, 1);

        // Back-to-back ticks: the second lands in SAMPLE and is ignored.
        set_ball(300, 0);
        frame_tick = 1'b1;
        wait_cyc(2);
        frame_tick = 1'b0;
        chk("dbl_early", int'(calc_start), 0);
        wait_cyc(1);
        chk("dbl_cs", int'(calc_start), 1);
        chk("dbl_coll", int'(collision), 2);
        wait_cyc(1);
        chk("dbl_off1", int'(calc_start), 0);
        wait_cyc(1);
        chk("dbl_off2", int'(calc_start), 0);

        // game_start drops during EVAL.
        set_ball(0, 0);
        frame_tick = 1'b1;
        wait_cyc(1);
        frame_tick = 1'b0;
        wait_cyc(1);
        game_start = 1'b0;
        wait_cyc(1);
        chk("gs_drop_cs", int'(calc_start), 0);
        chk("gs_drop_coll", int'(collision), 0);
        game_start = 1'b1;
        wait_cyc(1);
        do_frame("after_idle_paddle", 20, 100, 1, 1);
        do_frame("goal_in_lockout", 0, 0, 1, 4);

        // Reset asserted while in SAMPLE.
        set_ball(20, 100);
        frame_tick = 1'b1;
        wait_cyc(1);
        frame_tick = 1'b0;
        Reset      = 1'b1;
        wait_cyc(1);
        chk("rst_sample_cs", int'(calc_start), 0);
        chk("rst_sample_coll", int'(collision), 0);
        Reset = 1'b0;
        wait_cyc(1);
        chk("rst_no_strobe", int'(calc_start), 0);
        do_frame("after_reset_paddle", 20, 100, 1, 1);

        wait_cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_collision_detect.md
BALL_COLLISION_DETECT -- requirements
Module: ball_collision_detect

Interface
REQ-001 Parameter SCREEN_W, 640, playfield width in pixels.
REQ-002 Parameter SCREEN_H, 480, playfield height in pixels.
REQ-003 Parameter BALL_SIZE, 8, ball edge length in pixels.
REQ-004 Parameter PADDLE_W, 8, paddle width in pixels; PADDLE_H, 64, paddle height in pixels.
REQ-005 Parameter PADDLE_L_X, 16, left paddle left-edge x; PADDLE_R_X, 616, right paddle left-edge x.
REQ-006 Parameter LOCKOUT_FRAMES, 4, frames during which a repeat paddle collision is suppressed.
REQ-007 clk_100MHz  input  1  system clock; all logic on the rising edge.
REQ-008 Reset  input  1  synchronous, active-high reset.
REQ-009 game_start  input  1  game running when high; low forces IDLE.
REQ-010 frame_tick  input  1  one-cycle pulse per video frame; triggers one evaluation.
REQ-011 ball_x, ball_y  input  10 each  ball top-left position, pixels.
REQ-012 paddle_l_y, paddle_r_y  input  10 each  paddle top-edge y, pixels.
REQ-013 collision  output  3  code: 000 none, 001 paddle, 010 top wall, 011 bottom wall, 100 left goal, 101 right goal.
REQ-014 calc_start  output  1  one-cycle strobe qualifying collision for the speed calculator.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_FRAME, SAMPLE, EVAL, REPORT.
REQ-016 IDLE -> WAIT_FRAME when game_start=1; any state -> IDLE on the cycle after game_start=0 is sampled.
REQ-017 WAIT_FRAME -> SAMPLE when frame_tick=1; ball_x, ball_y, paddle_l_y, paddle_r_y SHALL be registered on that same edge.
REQ-018 SAMPLE -> EVAL -> REPORT -> WAIT_FRAME unconditionally, one cycle each; frame_tick outside WAIT_FRAME SHALL be ignored (not queued).
REQ-019 All comparisons SHALL use 11-bit zero-extended sums; no wrap-around permitted.
REQ-020 Left goal: ball_x == 0. Right goal: ball_x + BALL_SIZE >= SCREEN_W.
REQ-021 Left paddle hit: ball_x < PADDLE_L_X + PADDLE_W and ball_x + BALL_SIZE > PADDLE_L_X and ball_y + BALL_SIZE > paddle_l_y and ball_y < paddle_l_y + PADDLE_H; right paddle hit is the same with PADDLE_R_X and paddle_r_y.
REQ-022 Top wall: ball_y == 0. Bottom wall: ball_y + BALL_SIZE >= SCREEN_H.
REQ-023 Simultaneous conditions SHALL resolve by priority: left goal > right goal > paddle > top wall > bottom wall.
REQ-024 A paddle hit SHALL be suppressed (treated as absent) while the lockout counter is nonzero; lower-priority conditions then apply.
REQ-025 On a reported paddle hit, the lockout counter SHALL load LOCKOUT_FRAMES; it SHALL decrement by 1 on each REPORT cycle when nonzero and SHALL saturate at 0.
REQ-026 In REPORT, calc_start SHALL be 1 for exactly one cycle if the resolved code is nonzero; otherwise it stays 0.
REQ-027 collision SHALL update in REPORT only when the code is nonzero and SHALL hold its value until the next nonzero report or IDLE.
REQ-028 Latency: frame_tick high at cycle N -> calc_start high at cycle N+3.
REQ-029 In IDLE: collision=000, calc_start=0, lockout counter=0.
REQ-030 calc_start SHALL never be high for two consecutive cycles.

Reset
REQ-031 Reset=1 SHALL force state IDLE, collision=000, calc_start=0, lockout=0, and clear the sampled registers, on the next edge, including mid-evaluation.
REQ-032 Reset SHALL take priority over game_start and frame_tick.

Verification
REQ-033 game_start=1, ball (20,100), paddle_l_y=80, frame_tick at N -> calc_start=1 and collision=001 at N+3 only.
REQ-034 Same ball position held for 5 further frames -> frames 1-4 give no strobe (lockout); frame 5 gives strobe with 001.
REQ-035 ball (0,0) -> collision=100 (left goal beats top wall); ball (632,472) -> 101.
REQ-036 ball (300,0) -> 010; ball (300,472) -> 011; ball (300,200) -> no strobe, collision keeps previous value.
REQ-037 game_start drops in the EVAL cycle -> no strobe, collision=000 next cycle; Reset in SAMPLE -> same response.
REQ-038 frame_tick pulses at N and N+1 -> exactly one strobe, at N+3.
